// File: rtl/video_packet_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// video_packet_framer
//
// Purpose:
//   Turns a raw camera pixel stream into Avalon-ST video packets. Each camera
//   frame becomes one packet. The first pixel carries startofpacket and the last
//   pixel carries endofpacket. A small skid FIFO absorbs ready-low gaps on the
//   output side. The input side has no backpressure, so a pixel that does not fit
//   is dropped and flagged. The last slot of the FIFO is reserved for the EOP
//   pixel, so every packet that has started always gets its end marker.
//
// Optional feature:
//   FRAMER_FRAME_COUNT_EN - adds output frame_count[15:0]. It counts EOP
//   transfers on the output side and wraps from 0xFFFF to 0.
//
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous reset, active low (0 = in reset)
//   pix_data[DW]       in   camera pixel
//   pix_valid          in   pix_data valid this cycle (no backpressure)
//   pix_sof            in   qualifies pix_valid: first pixel of a camera frame
//   out_data[DW]       out  packet pixel (FIFO head)
//   out_valid          out  FIFO not empty
//   out_ready          in   downstream accepts; transfer = out_valid & out_ready
//   out_startofpacket  out  head entry is pixel (0,0)
//   out_endofpacket    out  head entry is pixel (WIDTH-1,HEIGHT-1)
//   overflow           out  sticky: pixel dropped since last SOP enqueue
//   sync_error         out  sticky: pix_sof seen mid-frame since last SOP enqueue
//   dbg_state          out  framing FSM state (0 = SEEK, 1 = STREAM)
//   frame_count[16]    out  EOP transfers (only with FRAMER_FRAME_COUNT_EN)
//
// Handshake: a beat moves on a rising edge where out_valid & out_ready. While
// out_valid is high and out_ready is low, out_data/SOP/EOP hold steady.
// -----------------------------------------------------------------------------
module video_packet_framer #(
    parameter int DW     = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] pix_data,
    input  logic          pix_valid,
    input  logic          pix_sof,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_startofpacket,
    output logic          out_endofpacket,
    output logic          overflow,
    output logic          sync_error,
    output logic          dbg_state
`ifdef FRAMER_FRAME_COUNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_LIM  = CW'(DEPTH - 1);

    typedef enum logic {
        SEEK   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [XW-1:0]   r_x;
    logic [XW-1:0]   w_x_nx;
    logic [YW-1:0]   r_y;
    logic [YW-1:0]   w_y_nx;
    logic            r_overflow;
    logic            w_overflow_nx;
    logic            r_sync_error;
    logic            w_sync_error_nx;

    logic [DW+1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_pop;
    logic            w_push;
    logic            w_framed;
    logic            w_pos_sop;
    logic            w_pos_eop;
    logic            w_room;
    logic [DW+1:0]   w_head;

    // x and y are held at 0 in SEEK. So "position is last pixel" also covers
    // the single-pixel frame, where SOP and EOP land on the same pixel.
    assign w_pos_sop = (r_state == SEEK);
    assign w_pos_eop = (r_x == X_LAST) && (r_y == Y_LAST);

    // In SEEK, only a pixel with pix_sof starts a frame. In STREAM every pixel
    // belongs to the frame, even one that carries a stray pix_sof.
    assign w_framed = pix_valid && ((r_state == STREAM) || pix_sof);

    // The last FIFO slot is kept for the EOP pixel. The check uses the count
    // from before any pop in the same cycle.
    assign w_room = w_pos_eop ? (r_count < C_FULL) : (r_count < C_LIM);

    assign w_push = w_framed && w_room;
    assign w_pop  = (r_count != '0) && out_ready;

    // ---------------------------------------------------------------------
    // Framing FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= SEEK;
            r_x          <= '0;
            r_y          <= '0;
            r_overflow   <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_x          <= w_x_nx;
            r_y          <= w_y_nx;
            r_overflow   <= w_overflow_nx;
            r_sync_error <= w_sync_error_nx;
        end
    end

    // ---------------------------------------------------------------------
    // Framing FSM: next state, position and sticky flags
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nx      = r_state;
        w_x_nx          = r_x;
        w_y_nx          = r_y;
        w_overflow_nx   = r_overflow;
        w_sync_error_nx = r_sync_error;

        if (w_framed) begin
            if ((r_state == SEEK) && !w_room) begin
                // A refused frame start: nothing has been emitted yet, so
                // stay in SEEK and wait for the next pix_sof.
                w_overflow_nx = 1'b1;
            end else begin
                if (r_state == SEEK) begin
                    w_overflow_nx   = 1'b0;
                    w_sync_error_nx = 1'b0;
                end else begin
                    if (pix_sof) begin
                        w_sync_error_nx = 1'b1;
                    end
                    // Geometry still advances on a drop, so a later EOP
                    // lands on the correct pixel.
                    if (!w_room) begin
                        w_overflow_nx = 1'b1;
                    end
                end

                if (w_pos_eop) begin
                    w_state_nx = SEEK;
                    w_x_nx     = '0;
                    w_y_nx     = '0;
                end else begin
                    w_state_nx = STREAM;
                    if (r_x == X_LAST) begin
                        w_x_nx = '0;
                        w_y_nx = r_y + YW'(1);
                    end else begin
                        w_x_nx = r_x + XW'(1);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Skid FIFO: {sop, eop, data} per entry
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_pos_sop, w_pos_eop, pix_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The head is gated by out_valid. This keeps stale or uninitialised
    // entries off the outputs when the FIFO is empty.
    assign w_head            = r_mem[r_rd_ptr];
    assign out_valid         = (r_count != '0);
    assign out_data          = out_valid ? w_head[DW-1:0] : '0;
    assign out_endofpacket   = out_valid & w_head[DW];
    assign out_startofpacket = out_valid & w_head[DW+1];
    assign overflow          = r_overflow;
    assign sync_error        = r_sync_error;
    assign dbg_state         = (r_state == STREAM);

`ifdef FRAMER_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_count <= '0;
        end else if (w_pop && w_head[DW]) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_video_packet_framer.sv
`timescale 1ns/1ps
module tb_video_packet_framer;

    localparam int DW     = 16;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int DEPTH  = 4;

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_sof;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic          overflow;
    logic          sync_error;
    logic          dbg_state;
`ifdef FRAMER_FRAME_COUNT_EN
    logic [15:0]   frame_count;
`endif

    always #5 clk = ~clk;

    video_packet_framer #(
        .DW     (DW),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_sof           (pix_sof),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .overflow          (overflow),
        .sync_error        (sync_error),
        .dbg_state         (dbg_state)
`ifdef FRAMER_FRAME_COUNT_EN
        ,
        .frame_count       (frame_count)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int            total = 0;
    int            bad   = 0;
    logic [DW+1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    logic          prev_hold = 1'b0;
    logic [DW+1:0] prev_head = '0;

    // Sample on the falling edge. Inputs change just after the rising edge,
    // so what is seen here is exactly what the next rising edge acts on.
    always @(negedge clk) begin
        logic [DW+1:0] cur;
        logic [DW+1:0] e;
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            cur = {out_startofpacket, out_endofpacket, out_data};
            if (prev_hold && out_valid) begin
                check("hold_stable", 32'(cur), 32'(prev_head));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got=%0h exp=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", 32'(cur), 32'(e));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_head = cur;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic expect_beat(input logic s, input logic e, input logic [DW-1:0] d);
        exp_q.push_back({s, e, d});
    endtask

    // One full WIDTH*HEIGHT frame. A stray pix_sof goes on pixel sof_at
    // (use -1 for none). Every pixel is expected at the output.
    task automatic send_frame(input logic [DW-1:0] base, input int sof_at);
        for (int p = 0; p < WIDTH * HEIGHT; p++) begin
            expect_beat(p == 0, p == WIDTH * HEIGHT - 1, base + DW'(p));
            drive(1'b1, (p == 0) || (p == sof_at), base + DW'(p));
        end
    endtask

    task automatic drain(input int max_cycles, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    typedef struct {
        logic          v;
        logic          s;
        logic [DW-1:0] d;
        logic          push;
        logic          sop;
        logic          eop;
    } vec_t;

    vec_t vt[11];

    initial begin
        reset     = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        out_ready = 1'b0;

        // Table: unframed pixels in SEEK, an idle cycle, then a framed 4x2 frame.
        vt[0]  = '{1'b1, 1'b0, 16'h00AA, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 16'h00BB, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 16'h00CC, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",    32'(out_valid),         32'd0);
        check("rst_sop",      32'(out_startofpacket), 32'd0);
        check("rst_eop",      32'(out_endofpacket),   32'd0);
        check("rst_data",     32'(out_data),          32'd0);
        check("rst_overflow", 32'(overflow),          32'd0);
        check("rst_syncerr",  32'(sync_error),        32'd0);
        check("rst_state",    32'(dbg_state),         32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Tests 1 and 2: basic framing, discarding of unframed pixels
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (vt[i].push) begin
                expect_beat(vt[i].sop, vt[i].eop, vt[i].d);
            end
            drive(vt[i].v, vt[i].s, vt[i].d);
            if (i == 4) begin
                check("t1_state_stream", 32'(dbg_state), 32'd1);
            end
        end
        drain(20, "t1_drain");
        check("t1_overflow", 32'(overflow),   32'd0);
        check("t1_syncerr",  32'(sync_error), 32'd0);
        check("t1_idle",     32'(out_valid),  32'd0);
        check("t1_state",    32'(dbg_state),  32'd0);

        // Test 3: backpressure fills the FIFO; the reserved slot takes EOP.
        out_ready = 1'b0;
        expect_beat(1'b1, 1'b0, 16'h0030);
        expect_beat(1'b0, 1'b0, 16'h0031);
        expect_beat(1'b0, 1'b0, 16'h0032);
        expect_beat(1'b0, 1'b1, 16'h0037);
        for (int p = 0; p < 8; p++) begin
            drive(1'b1, p == 0, 16'h0030 + DW'(p));
        end
        tick();
        check("t3_valid",    32'(out_valid),         32'd1);
        check("t3_overflow", 32'(overflow),          32'd1);
        check("t3_head",     32'(out_data),          32'h30);
        check("t3_head_sop", 32'(out_startofpacket), 32'd1);
        check("t3_state",    32'(dbg_state),         32'd0);
        out_ready = 1'b1;
        drain(20, "t3_drain");
        check("t3_idle",           32'(out_valid), 32'd0);
        check("t3_overflow_stick", 32'(overflow),  32'd1);

        // Test 4: stray pix_sof mid-frame
        send_frame(16'h0040, 3);
        drain(20, "t4_drain");
        check("t4_syncerr",     32'(sync_error), 32'd1);
        check("t4_overflow_clr", 32'(overflow),  32'd0);
        send_frame(16'h0050, -1);
        drain(20, "t4b_drain");
        check("t4_syncerr_clr", 32'(sync_error), 32'd0);

        // Test 5: asynchronous reset with entries queued mid-frame
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 16'h0070);
        drive(1'b1, 1'b0, 16'h0071);
        check("t5_queued", 32'(out_valid), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid),         32'd0);
        check("t5_rst_sop",   32'(out_startofpacket), 32'd0);
        check("t5_rst_state", 32'(dbg_state),         32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        drive(1'b1, 1'b0, 16'h007F);
        out_ready = 1'b1;
        send_frame(16'h0060, -1);
        drain(20, "t5_drain");
        check("t5_overflow", 32'(overflow), 32'd0);

        // Test 6: ready toggles; a pixel every other cycle; three frames
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int c = 0; c < 48; c++) begin
            int p;
            out_ready = (c % 2 == 0);
            if (c % 2 == 0) begin
                p = c / 2;
                expect_beat(p % 8 == 0, p % 8 == 7, DW'(256 + p));
                drive(1'b1, p % 8 == 0, DW'(256 + p));
            end else begin
                tick();
            end
        end
        out_ready = 1'b1;
        drain(20, "t6_drain");
        check("t6_overflow", 32'(overflow), 32'd0);
`ifdef FRAMER_FRAME_COUNT_EN
        check("t6_frame_count", 32'(frame_count), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
